// File: rtl/lsu_stage_if.sv
// Bundles for lsu_stage: execute-side request/writeback/exception and data-memory bus.
// Combinational wiring only; no latency.
// Flow control is carried by req_valid/req_ready and mem_req/mem_gnt/mem_rvalid.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready, wb_valid, wb_rd, wb_data, exc_valid, exc_cause, exc_addr
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready, wb_valid, wb_rd, wb_data, exc_valid, exc_cause, exc_addr
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_stage.sv
// Load/store unit: one data-memory access at a time, lane alignment, load extension, exceptions.
// Latency: load 3 cycles accept-to-wb with zero-wait memory, store 3 to ready, exception 1.
// Backpressure: req_ready only in IDLE; memory stalls via mem_gnt/mem_rvalid up to TIMEOUT cycles.
module lsu_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem,
    output logic      busy
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_EXC} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [4:0]  r_rd;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_wb_data;
    logic [1:0]  r_exc_cause;
    logic [31:0] r_exc_addr;
    logic [7:0]  r_cnt;

    logic        w_accept, w_illegal, w_misal, w_cnt_last, w_exc_set, w_capture;
    logic [1:0]  w_exc_cause;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_ld_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_accept   = req.req_valid && req.req_ready;
    assign w_illegal  = (req.req_funct3 == 3'b011) || (req.req_funct3[2:1] == 2'b11) ||
                        (req.req_we && req.req_funct3[2]);
    assign w_misal    = ((req.req_funct3[1:0] == 2'b01) && req.req_addr[0]) ||
                        ((req.req_funct3[1:0] == 2'b10) && (req.req_addr[1:0] != 2'b00));
    // >= so a grant on the last REQ cycle still leaves exactly one WAIT cycle for rvalid
    assign w_cnt_last = (r_cnt >= 8'(TIMEOUT - 1));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req.req_wdata;
        case (req.req_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << req.req_addr[1:0];
                w_wdata = {4{req.req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = req.req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = mem.mem_rdata[7:0];
        case (r_addr[1:0])
            2'b01:   w_byte = mem.mem_rdata[15:8];
            2'b10:   w_byte = mem.mem_rdata[23:16];
            2'b11:   w_byte = mem.mem_rdata[31:24];
            default: ;
        endcase
        w_half = r_addr[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {24'd0, w_byte};
            3'b101:  w_ld_data = {16'd0, w_half};
            default: w_ld_data = mem.mem_rdata;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_exc_set   = 1'b0;
        w_exc_cause = 2'b11;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_illegal || w_misal) begin
                        w_state_nxt = S_EXC;
                        w_exc_set   = 1'b1;
                        w_exc_cause = w_illegal ? 2'b00 : (req.req_we ? 2'b10 : 2'b01);
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem.mem_gnt) begin
                    w_state_nxt = S_WAIT;
                end else if (w_cnt_last) begin
                    w_state_nxt = S_EXC;
                    w_exc_set   = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem.mem_rvalid) begin
                    w_capture   = !r_we;
                    w_state_nxt = r_we ? S_IDLE : S_RESP;
                end else if (w_cnt_last) begin
                    w_state_nxt = S_EXC;
                    w_exc_set   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr      <= 32'd0;
            r_rd        <= 5'd0;
            r_be        <= 4'd0;
            r_wdata     <= 32'd0;
            r_wb_data   <= 32'd0;
            r_exc_cause <= 2'd0;
            r_exc_addr  <= 32'd0;
            r_cnt       <= 8'd0;
        end else begin
            if (w_accept) begin
                r_we     <= req.req_we;
                r_funct3 <= req.req_funct3;
                r_addr   <= req.req_addr;
                r_rd     <= req.req_rd;
                r_be     <= w_be;
                r_wdata  <= w_wdata;
                r_cnt    <= 8'd0;
            end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_capture) r_wb_data <= w_ld_data;
            if (w_exc_set) begin
                r_exc_cause <= w_exc_cause;
                r_exc_addr  <= (r_state == S_IDLE) ? req.req_addr : r_addr;
            end
        end
    end

    assign req.req_ready = rst_n && (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign req.wb_valid  = (r_state == S_RESP);
    assign req.wb_rd     = r_rd;
    assign req.wb_data   = r_wb_data;
    assign req.exc_valid = (r_state == S_EXC);
    assign req.exc_cause = r_exc_cause;
    assign req.exc_addr  = r_exc_addr;
    assign mem.mem_req   = (r_state == S_REQ);
    assign mem.mem_addr  = {r_addr[31:2], 2'b00};
    assign mem.mem_we    = r_we;
    assign mem.mem_be    = r_be;
    assign mem.mem_wdata = r_wdata;
endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: scoreboarded writeback/exception results plus cycle-exact checks.
module tb_lsu_stage;
    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    always #5 clk = ~clk;

    lsu_req_if rif();
    lsu_mem_if mif();

    lsu_stage #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rif),
        .mem   (mif),
        .busy  (busy)
    );

    typedef struct packed {logic [4:0] rd; logic [31:0] data;} wb_exp_t;
    typedef struct packed {logic [1:0] cause; logic [31:0] addr;} exc_exp_t;
    wb_exp_t  sb_wb[$];
    exc_exp_t sb_exc[$];
    wb_exp_t  wexp;
    exc_exp_t eexp;
    int total = 0;
    int bad   = 0;
    int n;

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_ctl"}, 32'({mif.mem_req, mif.mem_we, mif.mem_be, rif.wb_valid, rif.exc_valid,
                                busy, rif.wb_rd, rif.exc_cause, rif.req_ready}), 0);
        chk({tag, "_mem_addr"}, mif.mem_addr, 0);
        chk({tag, "_mem_wdata"}, mif.mem_wdata, 0);
        chk({tag, "_wb_data"}, rif.wb_data, 0);
        chk({tag, "_exc_addr"}, rif.exc_addr, 0);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
        chk("issue_ready", 32'(rif.req_ready), 1);
        rif.req_valid = 1'b1;  rif.req_we = we;  rif.req_funct3 = f3;
        rif.req_addr = addr;   rif.req_wdata = wd;  rif.req_rd = rd;
        cyc();
        rif.req_valid = 1'b0;
    endtask

    // Starts in the first REQ cycle; grant after gdly stall cycles, rvalid rdly cycles later.
    task automatic serve(input int gdly, input int rdly, input logic [31:0] rdata);
        logic [31:0] a, wd;
        logic [3:0]  be;
        a = mif.mem_addr;  wd = mif.mem_wdata;  be = mif.mem_be;
        for (int i = 0; i <= gdly; i++) begin
            chk("hold_req", 32'(mif.mem_req), 1);
            chk("hold_addr", mif.mem_addr, a);
            chk("hold_be", 32'(mif.mem_be), 32'(be));
            chk("hold_wdata", mif.mem_wdata, wd);
            mif.mem_gnt = (i == gdly);
            cyc();
        end
        mif.mem_gnt = 1'b0;
        repeat (rdly) cyc();
        mif.mem_rvalid = 1'b1;  mif.mem_rdata = rdata;
        cyc();
        mif.mem_rvalid = 1'b0;
    endtask

    task automatic to_idle();
        int k = 0;
        while (rif.req_ready !== 1'b1 && k < 8) begin k++; cyc(); end
        chk("to_idle_ready", 32'(rif.req_ready), 1);
    endtask

    task automatic exc_case(string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [1:0] cause);
        sb_exc.push_back('{cause: cause, addr: addr});
        issue(we, f3, addr, 32'h5555_AAAA, 5'd1);
        chk({tag, "_exc_pulse"}, 32'(rif.exc_valid), 1);
        chk({tag, "_no_req1"}, 32'(mif.mem_req), 0);
        cyc();
        chk({tag, "_exc_end"}, 32'(rif.exc_valid), 0);
        chk({tag, "_no_req2"}, 32'(mif.mem_req), 0);
        chk({tag, "_ready"}, 32'(rif.req_ready), 1);
        chk({tag, "_addr_hold"}, rif.exc_addr, addr);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rif.wb_valid === 1'b1) begin
            total++;
            assert (sb_wb.size() > 0) else begin
                bad++;
                $error("FAIL wb_unexpected observed=rd%0d expected=no_pulse", rif.wb_rd);
            end
            if (sb_wb.size() > 0) begin
                wexp = sb_wb.pop_front();
                chk("sb_wb_rd", 32'(rif.wb_rd), 32'(wexp.rd));
                chk("sb_wb_data", rif.wb_data, wexp.data);
            end
        end
        if (rst_n === 1'b1 && rif.exc_valid === 1'b1) begin
            total++;
            assert (sb_exc.size() > 0) else begin
                bad++;
                $error("FAIL exc_unexpected observed=cause%0d expected=no_pulse", rif.exc_cause);
            end
            if (sb_exc.size() > 0) begin
                eexp = sb_exc.pop_front();
                chk("sb_exc_cause", 32'(rif.exc_cause), 32'(eexp.cause));
                chk("sb_exc_addr", rif.exc_addr, eexp.addr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        rif.req_valid = 1'b0;  rif.req_we = 1'b0;  rif.req_funct3 = 3'd0;
        rif.req_addr = 32'd0;  rif.req_wdata = 32'd0;  rif.req_rd = 5'd0;
        mif.mem_gnt = 1'b0;  mif.mem_rvalid = 1'b0;  mif.mem_rdata = 32'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        #1;
        chk("release_ready", 32'(rif.req_ready), 1);
        chk("release_busy", 32'(busy), 0);
        cyc();

        // LB, zero-wait memory, cycle-exact
        sb_wb.push_back('{rd: 5'd5, data: 32'hFFFF_FF80});
        issue(1'b0, 3'b000, 32'h1003, 32'd0, 5'd5);
        chk("lb_mem_req", 32'(mif.mem_req), 1);
        chk("lb_mem_addr", mif.mem_addr, 32'h1000);
        chk("lb_mem_be", 32'(mif.mem_be), 32'h8);
        chk("lb_mem_we", 32'(mif.mem_we), 0);
        chk("lb_busy", 32'(busy), 1);
        mif.mem_gnt = 1'b1;
        cyc();
        mif.mem_gnt = 1'b0;
        mif.mem_rvalid = 1'b1;  mif.mem_rdata = 32'h80AA_BBCC;
        chk("lb_wb_cyc2", 32'(rif.wb_valid), 0);
        cyc();
        mif.mem_rvalid = 1'b0;
        chk("lb_wb_cyc3", 32'(rif.wb_valid), 1);
        chk("lb_wb_rd", 32'(rif.wb_rd), 5);
        cyc();
        chk("lb_ready_cyc4", 32'(rif.req_ready), 1);
        chk("lb_wb_cyc4", 32'(rif.wb_valid), 0);

        // LBU of the same byte
        sb_wb.push_back('{rd: 5'd6, data: 32'h0000_0080});
        issue(1'b0, 3'b100, 32'h1003, 32'd0, 5'd6);
        serve(0, 0, 32'h80AA_BBCC);
        chk("lbu_wb", 32'(rif.wb_valid), 1);
        to_idle();

        // SH to upper half
        issue(1'b1, 3'b001, 32'h2002, 32'h1234_ABCD, 5'd0);
        chk("sh_mem_we", 32'(mif.mem_we), 1);
        chk("sh_mem_be", 32'(mif.mem_be), 32'hC);
        chk("sh_mem_wdata", mif.mem_wdata, 32'hABCD_ABCD);
        chk("sh_mem_addr", mif.mem_addr, 32'h2000);
        mif.mem_gnt = 1'b1;
        cyc();
        mif.mem_gnt = 1'b0;
        mif.mem_rvalid = 1'b1;
        chk("sh_ready_cyc2", 32'(rif.req_ready), 0);
        cyc();
        mif.mem_rvalid = 1'b0;
        chk("sh_ready_cyc3", 32'(rif.req_ready), 1);
        chk("sh_no_wb", 32'(rif.wb_valid), 0);

        exc_case("lw_mis", 1'b0, 3'b010, 32'h3001, 2'b01);
        exc_case("sh_mis", 1'b1, 3'b001, 32'h3003, 2'b10);
        exc_case("f3_011", 1'b0, 3'b011, 32'h3004, 2'b00);
        exc_case("sbu_ill", 1'b1, 3'b100, 32'h3008, 2'b00);

        // Grant never arrives
        sb_exc.push_back('{cause: 2'b11, addr: 32'h4000});
        issue(1'b0, 3'b010, 32'h4000, 32'd0, 5'd7);
        n = 0;
        while (mif.mem_req === 1'b1 && n < 40) begin n++; cyc(); end
        chk("to_req_cycles", n, 16);
        chk("to_exc_valid", 32'(rif.exc_valid), 1);
        chk("to_exc_cause", 32'(rif.exc_cause), 32'h3);
        cyc();
        chk("to_ready", 32'(rif.req_ready), 1);
        mif.mem_rvalid = 1'b1;  mif.mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("to_late_no_wb", 32'(rif.wb_valid), 0);
        end
        mif.mem_rvalid = 1'b0;

        // LHU, grant after 5 stalls, rvalid 3 cycles later
        sb_wb.push_back('{rd: 5'd9, data: 32'h0000_BEEF});
        issue(1'b0, 3'b101, 32'h5002, 32'd0, 5'd9);
        chk("dly_addr", mif.mem_addr, 32'h5000);
        chk("dly_be", 32'(mif.mem_be), 32'hC);
        serve(5, 3, 32'hBEEF_1234);
        chk("dly_wb", 32'(rif.wb_valid), 1);
        to_idle();

        // LH granted on the timeout cycle
        sb_wb.push_back('{rd: 5'd10, data: 32'hFFFF_8001});
        issue(1'b0, 3'b001, 32'h6000, 32'd0, 5'd10);
        serve(15, 0, 32'h1234_8001);
        chk("gto_wb", 32'(rif.wb_valid), 1);
        chk("gto_no_exc", 32'(rif.exc_valid), 0);
        to_idle();

        // Reset while waiting for the response
        issue(1'b0, 3'b010, 32'h7000, 32'd0, 5'd3);
        mif.mem_gnt = 1'b1;
        cyc();
        mif.mem_gnt = 1'b0;
        chk("rstw_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_zero("rst_wait");
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rstw_release_ready", 32'(rif.req_ready), 1);
        cyc();
        sb_wb.push_back('{rd: 5'd4, data: 32'hCAFE_F00D});
        issue(1'b0, 3'b010, 32'h7004, 32'd0, 5'd4);
        chk("rstw_lw_addr", mif.mem_addr, 32'h7004);
        chk("rstw_lw_be", 32'(mif.mem_be), 32'hF);
        serve(0, 1, 32'hCAFE_F00D);
        chk("rstw_lw_wb", 32'(rif.wb_valid), 1);
        to_idle();
        cyc();

        chk("sb_wb_drained", sb_wb.size(), 0);
        chk("sb_exc_drained", sb_exc.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
